// File: rtl/alu_pipe.sv
// Single-stage registered ALU: shifts, logic ops, add/sub with signed overflow,
// and set-on-compare, with results captured only on valid input cycles.
module alu_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [0:31] A,
   input  logic [0:31] B,
   input  logic [0:2]  ALUOp,
   input  logic [0:1]  ALUCruft,
   output logic [0:31] R,
   output logic        ovf,
   output logic        out_valid
);

   typedef enum logic [2:0] {
      OP_SHIFT = 3'b000,
      OP_AND   = 3'b001,
      OP_OR    = 3'b010,
      OP_XOR   = 3'b011,
      OP_ADDSUB= 3'b100,
      OP_EQ    = 3'b101,
      OP_LT    = 3'b110,
      OP_GT    = 3'b111
   } op_e;

   // Ports use ascending ranges with bit 0 as MSB; internally everything is
   // handled as conventional [31:0] so arithmetic reads naturally.
   logic [31:0] a, b;
   logic [2:0]  op_raw;
   op_e         op;
   logic        c0, c1;

   assign a      = A;
   assign b      = B;
   assign op_raw = ALUOp;
   assign op     = op_e'(op_raw);
   assign c0     = ALUCruft[0];
   assign c1     = ALUCruft[1];

   logic [4:0]  shamt;
   logic [31:0] sll_res, srl_res, sra_res, shift_res;

   assign shamt   = b[4:0];
   assign sll_res = a << shamt;
   assign srl_res = a >> shamt;
   assign sra_res = $signed(a) >>> shamt;

   // c1 selects a right shift; c0 then picks sign fill over zero fill.
   always_comb begin
      shift_res = sll_res;
      if (c1) begin
         shift_res = c0 ? sra_res : srl_res;
      end
   end

   // Subtraction is a + ~b + 1 so one adder and one overflow rule serve both.
   logic [31:0] b_eff, sum;
   logic        add_ovf;

   assign b_eff   = c0 ? ~b : b;
   assign sum     = a + b_eff + {31'b0, c0};
   assign add_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]);

   logic eq, lt_s, lt_u, gt_s, gt_u, lt, gt;

   assign eq   = (a == b);
   assign lt_s = ($signed(a) < $signed(b));
   assign gt_s = ($signed(a) > $signed(b));
   assign lt_u = (a < b);
   assign gt_u = (a > b);
   assign lt   = c1 ? lt_u : lt_s;
   assign gt   = c1 ? gt_u : gt_s;

   logic [31:0] res_d, res_q;
   logic        ovf_d, ovf_q;
   logic        vld_q;

   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      unique case (op)
         OP_SHIFT:  res_d = shift_res;
         OP_AND:    res_d = a & b;
         OP_OR:     res_d = a | b;
         OP_XOR:    res_d = a ^ b;
         OP_ADDSUB: begin
            res_d = sum;
            ovf_d = add_ovf;
         end
         OP_EQ:     res_d = {31'b0, (c0 ? eq : ~eq)};
         OP_LT:     res_d = {31'b0, (c0 ? lt : ~lt)};
         OP_GT:     res_d = {31'b0, (c0 ? gt : ~gt)};
         default:   res_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         ovf_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign R         = res_q;
   assign ovf       = ovf_q;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a capture process pushes reference results,
// a negedge monitor pops and compares, and hold/reset behaviour is tracked.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [0:31] A, B;
   logic [0:2]  alu_op;
   logic [0:1]  cruft;
   logic [0:31] R;
   logic        ovf;
   logic        out_valid;

   alu_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .ALUOp     (alu_op),
      .ALUCruft  (cruft),
      .R         (R),
      .ovf       (ovf),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r;
      logic        o;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        exp_ov = 1'b0;
   logic [31:0] last_r = '0;
   logic        last_ovf = 1'b0;

   // Reference model: straight from the operation table using wide integers.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic c0, input logic c1,
                                 output logic [31:0] r, output logic o);
      longint sa, sb, ua, ub, t;
      int     ia;
      int     s;
      logic   res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ia  = a;
      s   = int'(b % 32);
      r   = '0;
      o   = 1'b0;
      res = 1'b0;
      case (op)
         3'd0: begin
            if (!c1)     r = a << s;
            else if (!c0) r = a >> s;
            else          r = ia >>> s;
         end
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         3'd4: begin
            t = c0 ? (sa - sb) : (sa + sb);
            r = t[31:0];
            o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         3'd5: begin
            res = c0 ? (a == b) : (a != b);
            r   = {31'b0, res};
         end
         3'd6: begin
            res = c1 ? (ua < ub) : (sa < sb);
            if (!c0) res = !res;
            r = {31'b0, res};
         end
         default: begin
            res = c1 ? (ua > ub) : (sa > sb);
            if (!c0) res = !res;
            r = {31'b0, res};
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Capture the expected response at the same edge the DUT samples inputs.
   always @(posedge clk) begin
      exp_t        e;
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      if (rst_n) begin
         exp_ov = in_valid;
         if (in_valid) begin
            ra  = A;
            rb  = B;
            rop = alu_op;
            model(ra, rb, rop, cruft[0], cruft[1], e.r, e.o);
            q.push_back(e);
         end
      end else begin
         exp_ov = 1'b0;
      end
   end

   always @(negedge rst_n) exp_ov = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("rst_R", R, 32'h0);
         chk("rst_ovf", 32'(ovf), 32'h0);
         chk("rst_out_valid", 32'(out_valid), 32'h0);
         q.delete();
         last_r   = '0;
         last_ovf = 1'b0;
      end else begin
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         if (out_valid) begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL scoreboard_empty: out_valid=1 with no expected entry at %0t", $time);
            end else begin
               e = q.pop_front();
               chk("R", R, e.r);
               chk("ovf", 32'(ovf), 32'(e.o));
               last_r   = e.r;
               last_ovf = e.o;
            end
         end else begin
            chk("hold_R", R, last_r);
            chk("hold_ovf", 32'(ovf), 32'(last_ovf));
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [1:0] cr, input logic v);
      @(negedge clk);
      A        = a;
      B        = b;
      alu_op   = op;
      cruft    = cr;
      in_valid = v;
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners[5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      alu_op   = '0;
      cruft    = '0;
      #1;
      chk("por_R", R, 32'h0);
      chk("por_out_valid", 32'(out_valid), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed cases from the operation table.
      drive(32'd1, 32'd2, 3'b000, 2'b00, 1'b1);
      drive(32'h8000_0000, 32'd4, 3'b000, 2'b11, 1'b1);
      drive(32'h8000_0000, 32'd4, 3'b000, 2'b01, 1'b1);
      drive(32'h8000_0000, 32'd4, 3'b000, 2'b10, 1'b1);
      drive(32'h1234_5678, 32'hFFFF_FFE0, 3'b000, 2'b11, 1'b1);
      drive(32'd9, 32'd7, 3'b001, 2'b00, 1'b1);
      drive(32'd9, 32'd7, 3'b010, 2'b11, 1'b1);
      drive(32'd9, 32'd7, 3'b011, 2'b01, 1'b1);
      drive(32'd9, 32'd7, 3'b100, 2'b00, 1'b1);
      drive(32'd9, 32'd7, 3'b100, 2'b10, 1'b1);
      drive(32'd9, 32'd7, 3'b101, 2'b10, 1'b1);
      drive(32'd7, 32'd7, 3'b101, 2'b10, 1'b1);
      drive(32'd7, 32'd7, 3'b101, 2'b00, 1'b1);
      drive(32'd9, 32'd7, 3'b101, 2'b00, 1'b1);
      drive(32'd9, 32'd7, 3'b110, 2'b10, 1'b1);
      drive(32'd9, 32'd7, 3'b110, 2'b00, 1'b1);
      drive(32'd9, 32'd7, 3'b111, 2'b10, 1'b1);
      drive(32'd9, 32'd7, 3'b111, 2'b00, 1'b1);
      drive(32'hFFFF_FFFF, 32'd1, 3'b110, 2'b10, 1'b1);
      drive(32'hFFFF_FFFF, 32'd1, 3'b110, 2'b11, 1'b1);
      drive(32'h7FFF_FFFF, 32'd1, 3'b100, 2'b00, 1'b1);
      drive(32'h8000_0000, 32'd1, 3'b100, 2'b10, 1'b1);
      drive(32'h7FFF_FFFF, 32'd1, 3'b001, 2'b00, 1'b1);
      drive(32'h0, 32'h0, 3'b000, 2'b00, 1'b0);
      drive(32'hDEAD_BEEF, 32'h5, 3'b010, 2'b00, 1'b0);

      // Mid-stream reset between clock edges with a nonzero result in flight.
      drive(32'd5, 32'd3, 3'b100, 2'b00, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_R", R, 32'h0);
      chk("async_rst_ovf", 32'(ovf), 32'h0);
      chk("async_rst_out_valid", 32'(out_valid), 32'h0);
      repeat (3) drive($urandom, $urandom, 3'(($urandom_range(0, 7))), 2'b00, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (4) drive($urandom, $urandom, 3'b010, 2'b00, 1'b0);

      // Randomized traffic with idle gaps and corner operands.
      for (int i = 0; i < 3000; i++) begin
         drive(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
         if (i == 1500) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      drive(32'h0, 32'h0, 3'b000, 2'b00, 1'b0);
      drive(32'h0, 32'h0, 3'b000, 2'b00, 1'b0);
      @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Ports SHALL be, in order (bit 0 = MSB on every vector, declared [0:N-1]):
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operands/op valid this cycle.
REQ-005 A  input  32  operand A, two's complement.
REQ-006 B  input  32  operand B, two's complement; B[27:31] is the shift amount.
REQ-007 ALUOp  input  3  operation class.
REQ-008 ALUCruft  input  2  operation modifier; ALUCruft[0] = variant select, ALUCruft[1] = signedness or shift-arithmetic select.
REQ-009 R  output  32  registered result.
REQ-010 ovf  output  1  registered signed overflow flag (ADD/SUB only, else 0).
REQ-011 out_valid  output  1  registered copy of in_valid.

Function
REQ-012 Decode, with c0 = ALUCruft[0] and c1 = ALUCruft[1]:
- 000 shift: c0c1=00 SLL, 01 SRL (zero fill), 11 SRA (sign fill), 10 SLL.
- 001 AND; 010 OR; 011 XOR (ALUCruft ignored).
- 100: c0=0 ADD, c0=1 SUB (A-B); c1 ignored.
- 101: c0=1 SEQ (A==B), c0=0 SNE (A!=B); c1 ignored.
- 110: c0=1 SLT (A<B), c0=0 SGE (A>=B).
- 111: c0=1 SGT (A>B), c0=0 SLE (A<=B).
REQ-013 For ops 110/111 comparison SHALL be signed when c1=0 and unsigned when c1=1.
REQ-014 Set-type ops SHALL produce 32'h00000001 when true, 32'h00000000 when false.
REQ-015 ADD/SUB SHALL wrap modulo 2^32; carry out discarded.
REQ-016 ovf SHALL be 1 when ADD/SUB signed result overflows (operand signs cause sign mismatch), else 0.
REQ-017 Shift amount SHALL be B[27:31] (0-31); amount 0 returns A unchanged; upper bits of B ignored.
REQ-018 Latency SHALL be exactly one cycle: R, ovf, out_valid reflect inputs sampled at the previous rising clk edge.
REQ-019 R and ovf SHALL update only when in_valid=1; when in_valid=0 they hold their previous values.
REQ-020 out_valid SHALL equal in_valid registered every cycle.
REQ-021 No combinational path SHALL exist from any input to any output.
REQ-022 X-free: any undefined encoding SHALL still yield a defined result per REQ-012 (all 32 combinations covered).

Reset
REQ-023 rst_n=0 SHALL immediately (without clk) force R=32'h00000000, ovf=0, out_valid=0.
REQ-024 While rst_n=0 all outputs SHALL stay at reset values regardless of clk or inputs.
REQ-025 After rst_n rises, first update SHALL occur at the next rising clk edge with in_valid=1.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; no stale result appears after release.

Verification
REQ-027 A=1, B=2, op 000, cruft 00 -> next cycle R=0x00000004; cruft 11 with A=0x80000000, B=4 -> R=0xF8000000; cruft 01 -> R=0x08000000.
REQ-028 A=9, B=7: op 001 -> R=0x1; op 010 -> R=0xF; op 011 -> R=0xE; op 100 c0=0 -> R=0x10; op 100 c0=1 -> R=0x2.
REQ-029 Op 101: A=9,B=7 c0=1 -> 0; A=7,B=7 c0=1 -> 1; A=7,B=7 c0=0 -> 0; A=9,B=7 c0=0 -> 1.
REQ-030 A=9,B=7 c1=0: SLT -> 0, SGE -> 1, SGT -> 1, SLE -> 0; A=0xFFFFFFFF,B=1: SLT signed -> 1, unsigned (c1=1) -> 0.
REQ-031 ADD A=0x7FFFFFFF, B=1 -> R=0x80000000, ovf=1; SUB A=0x80000000, B=1 -> R=0x7FFFFFFF, ovf=1; AND -> ovf=0.
REQ-032 Drive rst_n=0 between clk edges with R nonzero -> R=0, out_valid=0 immediately; hold in_valid=0 after release -> R stays 0.
